// File: rtl/elevator_req_latch.sv
// Debounces car-panel and hall-call buttons and latches each accepted press as a request
// bit until that floor is serviced. Define ELEVATOR_REQ_CANCEL_EN to let a second press cancel a car request.
module elevator_req_latch #(
  parameter int FLOOR_MIN       = 1,
  parameter int FLOOR_MAX       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLOOR_MAX-1:0] btn_internal,
  input  logic [FLOOR_MAX-1:0] btn_up,
  input  logic [FLOOR_MAX-1:0] btn_down,
  input  logic [3:0]           current_floor,
  input  logic                 door_state,
  input  logic [1:0]           elevator_state,
  output logic [FLOOR_MAX-1:0] internal_req,
  output logic [FLOOR_MAX-1:0] external_up_req,
  output logic [FLOOR_MAX-1:0] external_down_req,
  output logic                 pending_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NB = 3 * FLOOR_MAX;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE_CYCLES - 1);

  // No up-call above the top floor, no down-call below the bottom floor.
  localparam logic [FLOOR_MAX-1:0] UP_MASK = ~(FLOOR_MAX'(1) << (FLOOR_MAX - 1));
  localparam logic [FLOOR_MAX-1:0] DN_MASK = ~FLOOR_MAX'(1);

  logic [NB-1:0]         raw_all;
  logic [NB-1:0]         acc_all;
  logic [NB-1:0][CW-1:0] cnt;

  logic [FLOOR_MAX-1:0] acc_int, acc_up, acc_dn;
  logic [FLOOR_MAX-1:0] svc_hit, clr_int, clr_up, clr_dn;
  logic [FLOOR_MAX-1:0] int_nxt, up_nxt, dn_nxt;
  int                   cf_int;

  assign raw_all = {btn_down, btn_up, btn_internal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int n = 0; n < NB; n++) begin
        if (!raw_all[n])
          cnt[n] <= '0;
        else if (cnt[n] != CNT_MAX)
          cnt[n] <= cnt[n] + 1'b1;
      end
    end
  end

  // One accept per hold: only the step into saturation counts.
  always_comb begin
    acc_all = '0;
    for (int n = 0; n < NB; n++)
      acc_all[n] = raw_all[n] && (cnt[n] == CNT_PRE);
  end

  assign acc_int = acc_all[FLOOR_MAX-1:0];
  assign acc_up  = acc_all[2*FLOOR_MAX-1:FLOOR_MAX] & UP_MASK;
  assign acc_dn  = acc_all[3*FLOOR_MAX-1:2*FLOOR_MAX] & DN_MASK;

  // An out-of-range floor matches no bit, so nothing clears.
  always_comb begin
    svc_hit = '0;
    cf_int  = int'(current_floor);
    for (int f = 0; f < FLOOR_MAX; f++)
      if (door_state && (cf_int == f + FLOOR_MIN))
        svc_hit[f] = 1'b1;
  end

  assign clr_int = svc_hit;
  assign clr_up  = svc_hit & {FLOOR_MAX{elevator_state != 2'b10}};
  assign clr_dn  = svc_hit & {FLOOR_MAX{elevator_state != 2'b01}};

  always_comb begin
`ifdef ELEVATOR_REQ_CANCEL_EN
    int_nxt = (internal_req ^ acc_int) & ~clr_int;
`else
    int_nxt = (internal_req | acc_int) & ~clr_int;
`endif
    up_nxt  = (external_up_req | acc_up) & ~clr_up;
    dn_nxt  = (external_down_req | acc_dn) & ~clr_dn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      internal_req      <= '0;
      external_up_req   <= '0;
      external_down_req <= '0;
      pending_any       <= 1'b0;
    end else begin
      internal_req      <= int_nxt;
      external_up_req   <= up_nxt;
      external_down_req <= dn_nxt;
      pending_any       <= |{internal_req, external_up_req, external_down_req};
    end
  end

endmodule

// File: doc/elevator_req_latch.md
# elevator_req_latch

Upstream request-capture stage for the `elevator` controller. It debounces the raw car-panel and hall-call buttons, latches each accepted press as a persistent request bit, and drives those bits as the `internal_req`, `external_up_req` and `external_down_req` levels the controller consumes. It watches the controller's `current_floor`, `door_state` and `elevator_state` outputs to clear a request once that floor has been serviced.

## Interface
- `FLOOR_MIN`, default 1: lowest floor number. Bit 0 of every vector maps to this floor.
- `FLOOR_MAX`, default 8: highest floor number, and the width of every request vector.
- `DEBOUNCE_CYCLES`, default 4: consecutive high samples required to accept a press. Must be ≥ 1.

Ports:
- `clk` input 1: single clock. All state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn_internal` input FLOOR_MAX: raw car-panel buttons, active-high.
- `btn_up` input FLOOR_MAX: raw hall up-call buttons.
- `btn_down` input FLOOR_MAX: raw hall down-call buttons.
- `current_floor` input 4: floor reported by the controller.
- `door_state` input 1: door status from the controller (1 = open).
- `elevator_state` input 2: controller direction (00 idle, 01 up, 10 down).
- `internal_req` output FLOOR_MAX: latched car requests.
- `external_up_req` output FLOOR_MAX: latched up-calls.
- `external_down_req` output FLOOR_MAX: latched down-calls.
- `pending_any` output 1: OR of all three request vectors, registered.

## Operation
- **Debounce counters.** There is one counter per raw button bit (3×FLOOR_MAX counters), each $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - Raw sampled 1: the counter increments and saturates at DEBOUNCE_CYCLES.
  - Raw sampled 0: the counter clears to 0.
- **Accept event.** An accept fires on the edge where the counter goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES.
  - Holding a button produces exactly one accept.
  - Re-triggering requires at least one sampled low.
- **Set.** An accept sets the matching request bit.
- **Masked buttons.** `btn_up[FLOOR_MAX-1]` and `btn_down[0]` are masked.
  - Their counters still run, but they never set a bit.
  - Those output bits are constant 0.
- **Service clear.** Service clearing is active when `door_state`=1 and FLOOR_MIN ≤ `current_floor` ≤ FLOOR_MAX. Let i = `current_floor` − FLOOR_MIN.
  - `internal_req[i]` clears.
  - `external_up_req[i]` clears if `elevator_state` ≠ 10.
  - `external_down_req[i]` clears if `elevator_state` ≠ 01.
- **Out-of-range floor.** If `current_floor` is out of range, nothing clears.
- **Set and clear on the same bit, same edge.** Clear wins, because a press at an open door is already served.
- **Multiple accepts.** Accepts on different bits in the same cycle are all latched. There is no arbitration.
- **`elevator_state` = 11.** Treated as idle: both hall directions clear.

## Timing
- **Reset.** Asynchronous. While `rst`=1, all counters, all three request vectors and `pending_any` are held at 0.
  - After deassert, a button that was held through reset is debounced from count 0 again.
- **Press latency.** Raw high sampled on edges 1..DEBOUNCE_CYCLES gives the request bit = 1 after edge DEBOUNCE_CYCLES.
  - `pending_any` follows one edge later.
- **Clear latency.** The request bit drops on the first edge that samples the service condition true.
- **Glitches.** A raw pulse shorter than DEBOUNCE_CYCLES samples never latches.
- **Persistence.** Request bits are held indefinitely until served or reset. Releasing the button does not clear them.

## Configuration
- `ELEVATOR_REQ_CANCEL_EN`, when defined: an accept on an `internal_req` bit that is already 1 clears that bit (toggle cancel).
  - Service clear still wins over a same-edge cancel or set.
  - Hall calls are unaffected.
- Without the macro: an accept on an already-set bit is a no-op.

## Test plan
All scenarios use defaults (FLOOR_MAX=8, DEBOUNCE_CYCLES=4).

1. **Basic press.** Hold `btn_internal[3]`=1 for 6 cycles with the door closed and floor 1 → `internal_req`=00001000 after the 4th sampled edge, and `pending_any`=1 one edge later.
2. **Glitch rejection.** Pulse `btn_up[5]` high for 3 cycles, low for 1, high for 3 → `external_up_req` stays 0.
3. **Direction-aware clear.**
   - Latch `btn_up[2]` and `btn_down[2]`, then drive `current_floor`=3, `door_state`=1, `elevator_state`=01 → `external_up_req[2]` clears next edge, `external_down_req[2]` stays 1.
   - Then switch to `elevator_state`=10 → `external_down_req[2]` clears.
4. **Boundary masking.** Hold `btn_up[7]` and `btn_down[0]` for 10 cycles → both outputs stay 0 and `pending_any`=0.
5. **Same-edge collision and held button.**
   - Press `btn_internal[4]` so its accept edge coincides with `current_floor`=5, `door_state`=1 → bit remains 0.
   - Keep holding → no re-latch.
6. **Reset and macro variants.**
   - Assert `rst` mid-debounce with 3 bits latched → all outputs 0 immediately.
   - With `ELEVATOR_REQ_CANCEL_EN`, a second full press of `btn_internal[1]` returns `internal_req[1]` to 0. Without it, the bit stays 1.
